ddr_rd_burst_asm: RTL
=====================

Name: ddr_rd_burst_asm

Overview:
- Read-path stage directly downstream of the DDR read deserialiser.
- Collects deserialised WIDTH-bit words, one per strobe, into complete bursts of BEATS words.
- Buffers up to DEPTH completed bursts in an internal FIFO and presents them to the controller's read-return logic over a valid/ready handshake.
- Flags burst misalignment and FIFO overflow with sticky status bits.

Parameters:
- WIDTH, 8: bits per deserialised word (one DQ byte lane).
- BEATS, 16: words per burst (BL16); must be >= 2.
- DEPTH, 4: burst lines held in the FIFO; power of two, >= 2.

Ports:
- clk_i  in  1  controller clock; all logic is posedge-triggered.
- rst_i  in  1  asynchronous, active-high reset.
- word_i  in  WIDTH  deserialised word; sampled only when word_vld_i=1.
- word_vld_i  in  1  one-cycle strobe: word_i holds a new word.
- burst_start_i  in  1  marks word_i as beat 0 of a burst; meaningful only with word_vld_i=1.
- line_o  out  WIDTH*BEATS  head burst; beat k occupies bits [k*WIDTH +: WIDTH]; all zero when line_vld_o=0.
- line_vld_o  out  1  FIFO non-empty.
- line_rdy_i  in  1  consumer accepts head line when line_vld_o=1.
- lvl_o  out  $clog2(DEPTH)+1  number of stored lines, 0..DEPTH.
- full_o  out  1  lvl_o==DEPTH.
- ovf_o  out  1  sticky: a completed line was dropped.
- err_align_o  out  1  sticky: orphan word or truncated burst detected.
- clr_err_i  in  1  synchronous clear of ovf_o and err_align_o.

Behaviour:
- Reset (async assert, sync release): state=IDLE, beat counter=0, assembly register=0, FIFO empty. Outputs: line_vld_o=0, line_o=0, lvl_o=0, full_o=0, ovf_o=0, err_align_o=0.
- Assembly FSM, transitions on word_vld_i=1 only. Cycles with word_vld_i=0 hold all state with no timeout; burst_start_i is ignored without word_vld_i.
  - IDLE + vld + start: store word at beat 0, cnt=1, go to COLLECT.
  - IDLE + vld + !start: discard the word, set err_align_o, stay in IDLE.
  - COLLECT + vld + !start: store word at beat cnt, cnt=cnt+1. On the write of beat BEATS-1, the line completes: push to the FIFO, cnt=0, go to IDLE.
  - COLLECT + vld + start: truncated burst. Discard the partial line, set err_align_o, store word as beat 0, cnt=1, stay in COLLECT.
- The assembly register is never cleared between bursts. Unwritten beats cannot reach the FIFO because only full lines are pushed.
- Latency: line_vld_o rises on the cycle after the edge that captured beat BEATS-1, when the FIFO was empty. There is no combinational path from word_i to line_o.
- FIFO: circular buffer with read/write pointers and a count of width $clog2(DEPTH)+1.
  - Pop: line_vld_o && line_rdy_i.
  - Push: line completion.
  - Push when full with no pop: line dropped, ovf_o set, stored lines untouched.
  - Push and pop in the same cycle when full: both accepted, lvl_o unchanged, no overflow.
  - Push and pop in the same cycle when lvl_o=1: both accepted, line_vld_o stays 1, new line appears next cycle.
  - Pointers wrap modulo DEPTH.
- Handshake: while line_vld_o && !line_rdy_i, line_o and line_vld_o hold stable. line_rdy_i while empty has no effect.
- Status: full_o and lvl_o are registered-derived with no combinational dependence on inputs. Sticky bits set the cycle after the event and stay set until clr_err_i. If clr_err_i coincides with a new event, set wins.
- Reset mid-burst or with FIFO occupied: partial line and all stored lines are discarded immediately, outputs return to reset values.

Test Plan:
- Nominal: start+16 words 0x00..0x0F, line_rdy_i=1 -> one cycle later line_vld_o=1, line_o=0x0F0E...0100, popped next edge, lvl_o back to 0.
- Backpressure/overflow: line_rdy_i=0, send 5 bursts -> lvl_o=4, full_o=1, 5th dropped, ovf_o=1. Then drain with rdy=1 -> bursts 1..4 emerge in order with no gaps. clr_err_i -> ovf_o=0.
- Full push+pop: FIFO holds 4, rdy=1 on the same cycle as the 5th completion -> lvl_o stays 4, ovf_o=0, 5th line emerges last.
- Misalignment: orphan word 0xAA in IDLE -> err_align_o=1, no line. 7 beats then a new start + 16 words 0x10..0x1F -> exactly one line, containing 0x1F..0x10.
- Gapped strobes: 16 words with random 0-3 idle cycles between them, plus stray burst_start_i=1 on idle cycles -> line identical to the gapless case, err_align_o=0.
- Async reset: assert rst_i mid-burst (beat 9) with 2 lines stored, off-edge -> line_vld_o=0, lvl_o=0 immediately. After release, a clean burst assembles correctly.

Source files
------------

// File: rtl/ddr_rd_burst_asm.sv
`default_nettype none
// ============================================================================
// Module      : ddr_rd_burst_asm
// Description : DDR read-path burst assembler. Gathers deserialised words,
//               one per strobe, into complete bursts of BEATS words. Buffers
//               up to DEPTH finished bursts in a circular FIFO and presents
//               them over a valid/ready handshake. Misalignment and FIFO
//               overflow are reported through sticky status bits.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i          controller clock, posedge
//   rst_i          asynchronous active-high reset
//   word_i         deserialised word, valid with word_vld_i
//   word_vld_i     one-cycle strobe, word_i carries a new word
//   burst_start_i  word_i is beat 0 of a burst (qualified by word_vld_i)
//   line_o         head burst, beat k at [k*WIDTH +: WIDTH], zero when empty
//   line_vld_o     FIFO non-empty
//   line_rdy_i     consumer accepts the head line
//   lvl_o          number of stored lines, 0..DEPTH
//   full_o         lvl_o == DEPTH
//   ovf_o          sticky: a completed line was dropped
//   err_align_o    sticky: orphan word or truncated burst
//   clr_err_i      synchronous clear of ovf_o and err_align_o
// ============================================================================
module ddr_rd_burst_asm #(
  parameter int WIDTH = 8,
  parameter int BEATS = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [WIDTH-1:0]           word_i,
  input  logic                       word_vld_i,
  input  logic                       burst_start_i,
  output logic [WIDTH*BEATS-1:0]     line_o,
  output logic                       line_vld_o,
  input  logic                       line_rdy_i,
  output logic [$clog2(DEPTH):0]     lvl_o,
  output logic                       full_o,
  output logic                       ovf_o,
  output logic                       err_align_o,
  input  logic                       clr_err_i
);

  localparam int LW = WIDTH * BEATS;
  localparam int CW = $clog2(BEATS);
  localparam int PW = $clog2(DEPTH);

  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [PW:0]   FULL_LVL  = (PW + 1)'(DEPTH);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Assembly state
  // --------------------------------------------------------------------------
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [LW-1:0]   asm_q;

  // --------------------------------------------------------------------------
  // FIFO state
  // --------------------------------------------------------------------------
  logic [LW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [PW:0]     lvl_q,  lvl_d;
  logic            ovf_q,  ovf_d;
  logic            err_q,  err_d;

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  logic            w_line_done;
  logic            w_align_evt;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_ovf_evt;
  logic [LW-1:0]   w_push_line;

  // The final beat is still on word_i when the line completes, so the pushed
  // line is the assembly register with its top beat replaced by that word.
  always_comb begin
    w_push_line                      = asm_q;
    w_push_line[LW-1 -: WIDTH]       = word_i;
  end

  assign w_line_done = word_vld_i && !burst_start_i &&
                       (state_q == ST_COLLECT) && (cnt_q == LAST_BEAT);

  // Orphan word in IDLE, or a new start interrupting a partial burst.
  assign w_align_evt = word_vld_i &&
                       (((state_q == ST_IDLE)    && !burst_start_i) ||
                        ((state_q == ST_COLLECT) &&  burst_start_i));

  assign w_empty   = (lvl_q == '0);
  assign w_full    = (lvl_q == FULL_LVL);
  assign w_pop     = !w_empty && line_rdy_i;
  // A full FIFO can still take a line if the head leaves on the same edge.
  assign w_push    = w_line_done && (!w_full || w_pop);
  assign w_ovf_evt = w_line_done &&  w_full && !w_pop;

  // --------------------------------------------------------------------------
  // Assembly FSM. Only strobed cycles advance; idle cycles hold everything.
  // The assembly register is never cleared between bursts: only complete
  // lines are pushed, so stale beats never escape.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      asm_q   <= '0;
    end else if (word_vld_i) begin
      case (state_q)
        ST_IDLE: begin
          if (burst_start_i) begin
            asm_q[0 +: WIDTH] <= word_i;
            cnt_q             <= CW'(1);
            state_q           <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (burst_start_i) begin
            // Truncated burst: restart with this word as beat 0.
            asm_q[0 +: WIDTH] <= word_i;
            cnt_q             <= CW'(1);
          end else begin
            asm_q[cnt_q*WIDTH +: WIDTH] <= word_i;
            if (cnt_q == LAST_BEAT) begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q   <= cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO pointer / level / status next-state
  // --------------------------------------------------------------------------
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    lvl_d  = lvl_q;
    if (w_push) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (w_pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    case ({w_push, w_pop})
      2'b10:   lvl_d = lvl_q + (PW + 1)'(1);
      2'b01:   lvl_d = lvl_q - (PW + 1)'(1);
      default: lvl_d = lvl_q;
    endcase
    // A new event in the same cycle as a clear leaves the bit set.
    ovf_d = w_ovf_evt   || (ovf_q && !clr_err_i);
    err_d = w_align_evt || (err_q && !clr_err_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      lvl_q  <= lvl_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

  // Storage needs no reset: entries are only visible while counted in lvl_q.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      mem_q[wptr_q] <= w_push_line;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, all derived from registers only
  // --------------------------------------------------------------------------
  assign line_vld_o  = !w_empty;
  assign line_o      = w_empty ? '0 : mem_q[rptr_q];
  assign lvl_o       = lvl_q;
  assign full_o      = w_full;
  assign ovf_o       = ovf_q;
  assign err_align_o = err_q;

endmodule
`default_nettype wire
